tuple_pacer: RTL and testbench

Rate-controlled scheduler that sequences the read side of the packet-tuple FIFO (`fallthrough_small_fifo_v2`, `{five-tuple, pkt_len}` entries) and releases tuples to the packet builder at a programmed byte rate. It uses a token bucket. Tokens accrue per cycle and each released tuple is charged its packet length. It also enforces an optional packet-count limit, after which it stops and flags done. It replaces the free-running pop logic between the tuple FIFO and the builder.

---
 rtl/tuple_pacer_pkg.sv | 32 +++
 rtl/tuple_pacer_if.sv | 28 ++
 rtl/token_bucket.sv | 51 +++++
 rtl/tuple_pacer.sv | 123 ++++++++++++
 tb/tb_tuple_pacer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tuple_pacer_pkg.sv
// Shared types and constants for the tuple pacer.
// Optional feature macro: TUPLE_PACER_IFG_EN adds preamble + IFG bytes to each packet's charge.
package tuple_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Preamble (8) + inter-frame gap (12) bytes on the wire per packet.
  localparam int IFG_OVERHEAD   = 20;

  // FIFO entry layout: {tuple, len}, length in the LSBs.
  localparam int FIFO_LEN_LSB   = 0;
  localparam int FIFO_LEN_WIDTH = 16;
  localparam int CHARGE_WIDTH   = FIFO_LEN_WIDTH + 1;

  function automatic int fifo_tuple_msb(input int pkt_tuple_width);
    return pkt_tuple_width + FIFO_LEN_WIDTH - 1;
  endfunction

  function automatic logic [CHARGE_WIDTH-1:0] pkt_charge(input logic [FIFO_LEN_WIDTH-1:0] len);
`ifdef TUPLE_PACER_IFG_EN
    return CHARGE_WIDTH'(len) + CHARGE_WIDTH'(IFG_OVERHEAD);
`else
    return CHARGE_WIDTH'(len);
`endif
  endfunction

endpackage

// File: rtl/tuple_pacer_if.sv
// FIFO read side and builder-facing output of the tuple pacer.
// master = pacer, slave = FIFO/builder environment.
interface tuple_pacer_if #(
  parameter int PKT_TUPLE_WIDTH    = 104,
  parameter int ACTION_TUPLE_WIDTH = 128,
  parameter int PKT_LEN_WIDTH      = 16
);
  import tuple_pacer_pkg::*;

  logic [PKT_TUPLE_WIDTH+FIFO_LEN_WIDTH-1:0] fifo_dout;
  logic                                      fifo_empty;
  logic                                      fifo_rd_en;
  logic [ACTION_TUPLE_WIDTH-1:0]             tuple_out;
  logic [PKT_LEN_WIDTH-1:0]                  pkt_len_out;
  logic                                      tuple_out_vld;
  logic                                      tuple_out_ready;

  modport master (
    input  fifo_dout, fifo_empty, tuple_out_ready,
    output fifo_rd_en, tuple_out, pkt_len_out, tuple_out_vld
  );

  modport slave (
    output fifo_dout, fifo_empty, tuple_out_ready,
    input  fifo_rd_en, tuple_out, pkt_len_out, tuple_out_vld
  );

endinterface

// File: rtl/token_bucket.sv
// Byte-credit bucket: loads to burst, accrues rate per cycle, debits a packet charge.
// can_send also fires when the bucket is full so oversized packets still drain.
module token_bucket
  import tuple_pacer_pkg::*;
#(
  parameter int TOKEN_WIDTH = 24,
  parameter int RATE_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic                    accrue_en,
  input  logic [CHARGE_WIDTH-1:0] debit,
  input  logic [CHARGE_WIDTH-1:0] charge,
  input  logic [RATE_WIDTH-1:0]   rate,
  input  logic [TOKEN_WIDTH-1:0]  burst,
  output logic [TOKEN_WIDTH-1:0]  tokens,
  output logic                    can_send
);

  // Two spare bits so subtract-then-add can never wrap.
  localparam int SUM_WIDTH = TOKEN_WIDTH + 2;

  logic [SUM_WIDTH-1:0]   tokens_w;
  logic [SUM_WIDTH-1:0]   debit_w;
  logic [SUM_WIDTH-1:0]   left_w;
  logic [SUM_WIDTH-1:0]   sum_w;
  logic [TOKEN_WIDTH-1:0] tokens_next;

  always_comb begin
    tokens_w    = SUM_WIDTH'(tokens);
    debit_w     = SUM_WIDTH'(debit);
    left_w      = (tokens_w > debit_w) ? (tokens_w - debit_w) : '0;
    sum_w       = left_w + SUM_WIDTH'(rate);
    tokens_next = (sum_w > SUM_WIDTH'(burst)) ? burst : sum_w[TOKEN_WIDTH-1:0];
  end

  assign can_send = (tokens >= TOKEN_WIDTH'(charge)) || (tokens == burst);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tokens <= '0;
    end else if (load) begin
      tokens <= burst;
    end else if (accrue_en) begin
      tokens <= tokens_next;
    end
  end

endmodule

// File: rtl/tuple_pacer.sv
// Rate-controlled pop scheduler between the tuple FIFO and the packet builder.
// Charge includes IFG overhead when TUPLE_PACER_IFG_EN is defined.
module tuple_pacer
  import tuple_pacer_pkg::*;
#(
  parameter int PKT_TUPLE_WIDTH    = 104,
  parameter int ACTION_TUPLE_WIDTH = 128,
  parameter int PKT_LEN_WIDTH      = 16,
  parameter int TOKEN_WIDTH        = 24,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cfg_enable,
  input  logic [15:0]            cfg_rate,
  input  logic [TOKEN_WIDTH-1:0] cfg_burst,
  input  logic [CNT_WIDTH-1:0]   cfg_pkt_limit,
  tuple_pacer_if.master          bus,
  output logic [CNT_WIDTH-1:0]   sent_cnt,
  output logic                   done
);

  localparam int TUPLE_MSB = fifo_tuple_msb(PKT_TUPLE_WIDTH);

  state_e                        state;
  state_e                        state_next;
  logic [FIFO_LEN_WIDTH-1:0]     head_len;
  logic [PKT_TUPLE_WIDTH-1:0]    head_tuple;
  logic [CHARGE_WIDTH-1:0]       head_charge;
  logic [CHARGE_WIDTH-1:0]       debit;
  logic [TOKEN_WIDTH-1:0]        tokens;
  logic                          can_send;
  logic                          load;
  logic                          pop;
  logic                          handshake;
  logic [CNT_WIDTH-1:0]          sent_inc;
  logic [ACTION_TUPLE_WIDTH-1:0] tuple_q;
  logic [PKT_LEN_WIDTH-1:0]      len_q;

  assign head_len    = bus.fifo_dout[FIFO_LEN_LSB +: FIFO_LEN_WIDTH];
  assign head_tuple  = bus.fifo_dout[TUPLE_MSB -: PKT_TUPLE_WIDTH];
  assign head_charge = pkt_charge(head_len);

  // Pop only from WAIT with a present head and enough credit (or a full bucket).
  assign pop       = (state == ST_WAIT) && cfg_enable && !bus.fifo_empty && can_send;
  assign handshake = (state == ST_SEND) && bus.tuple_out_ready;
  assign sent_inc  = sent_cnt + CNT_WIDTH'(1);
  assign debit     = pop ? head_charge : '0;

  token_bucket #(
    .TOKEN_WIDTH (TOKEN_WIDTH),
    .RATE_WIDTH  (16)
  ) u_bucket (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .accrue_en (state != ST_IDLE),
    .debit     (debit),
    .charge    (head_charge),
    .rate      (cfg_rate),
    .burst     (cfg_burst),
    .tokens    (tokens),
    .can_send  (can_send)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latch).
    state_next = state;
    load       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_enable) begin
          load       = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!cfg_enable) state_next = ST_IDLE;
        else if (pop)    state_next = ST_SEND;
      end
      ST_SEND: begin
        // A handshake in flight completes even if enable has dropped.
        if (bus.tuple_out_ready) begin
          if ((cfg_pkt_limit != '0) && (sent_inc == cfg_pkt_limit)) state_next = ST_DONE;
          else if (!cfg_enable)                                     state_next = ST_IDLE;
          else                                                      state_next = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (!cfg_enable) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tuple_q <= '0;
      len_q   <= '0;
    end else if (pop) begin
      tuple_q <= ACTION_TUPLE_WIDTH'(head_tuple);
      len_q   <= PKT_LEN_WIDTH'(head_len);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)        sent_cnt <= '0;
    else if (load)      sent_cnt <= '0;
    else if (handshake) sent_cnt <= sent_inc;
  end

  assign bus.fifo_rd_en    = pop;
  assign bus.tuple_out     = tuple_q;
  assign bus.pkt_len_out   = len_q;
  assign bus.tuple_out_vld = (state == ST_SEND);
  assign done              = (state == ST_DONE);

endmodule

// File: tb/tb_tuple_pacer.sv
// Bench for tuple_pacer: queue-backed FIFO, cycle-level pacing model, handshake scoreboard.
module tb_tuple_pacer;
  import tuple_pacer_pkg::*;

  localparam int PTW = 104;
  localparam int ATW = 128;
  localparam int PLW = 16;
  localparam int TW  = 24;
  localparam int CW  = 32;
  localparam int EW  = PTW + 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_enable;
  logic [15:0]   cfg_rate;
  logic [TW-1:0] cfg_burst;
  logic [CW-1:0] cfg_pkt_limit;
  logic [CW-1:0] sent_cnt;
  logic          done;

  tuple_pacer_if #(.PKT_TUPLE_WIDTH(PTW), .ACTION_TUPLE_WIDTH(ATW), .PKT_LEN_WIDTH(PLW)) bus ();

  tuple_pacer #(
    .PKT_TUPLE_WIDTH(PTW), .ACTION_TUPLE_WIDTH(ATW), .PKT_LEN_WIDTH(PLW),
    .TOKEN_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cfg_enable    (cfg_enable),
    .cfg_rate      (cfg_rate),
    .cfg_burst     (cfg_burst),
    .cfg_pkt_limit (cfg_pkt_limit),
    .bus           (bus),
    .sent_cnt      (sent_cnt),
    .done          (done)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Abstract model: credit level, whether running, holding a tuple, or finished.
  int m_bucket, m_sent;
  bit m_run, m_hold, m_fin;

  task automatic check(input string name, input logic [ATW-1:0] act, input logic [ATW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int charge_of(input int len);
`ifdef TUPLE_PACER_IFG_EN
    return len + 20;
`else
    return len;
`endif
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_dout  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_pkt(input int len);
    logic [PTW-1:0] t;
    logic [EW-1:0]  e;
    t = PTW'({$urandom, $urandom, $urandom, $urandom});
    e = {t, 16'(len)};
    fifo_q.push_back(e);
    exp_q.push_back(e);
    drive_fifo();
  endtask

  // One clock: compare against the model at negedge, advance model, let the FIFO react.
  task automatic cycle();
    int chg, nb;
    bit exp_pop, act_pop;
    @(negedge clk);
    chg     = (fifo_q.size() > 0) ? charge_of(int'(fifo_q[0][15:0])) : 0;
    exp_pop = m_run && !m_hold && !m_fin && (cfg_enable == 1'b1) && (fifo_q.size() > 0) &&
              ((m_bucket >= chg) || (m_bucket == int'(cfg_burst)));
    check("fifo_rd_en", ATW'(bus.fifo_rd_en), ATW'(exp_pop));
    check("tuple_out_vld", ATW'(bus.tuple_out_vld), ATW'(m_hold));
    check("done", ATW'(done), ATW'(m_fin));
    check("sent_cnt", ATW'(sent_cnt), ATW'(m_sent));
    check("tokens", ATW'(dut.tokens), ATW'(m_bucket));
    act_pop = bus.fifo_rd_en;

    if (!resetn) begin
      if (m_hold && exp_q.size() > 0) void'(exp_q.pop_front());
      m_bucket = 0; m_sent = 0; m_run = 0; m_hold = 0; m_fin = 0;
    end else if (!m_run) begin
      if (cfg_enable) begin
        m_bucket = int'(cfg_burst);
        m_sent   = 0;
        m_run    = 1;
      end
    end else begin
      nb = m_bucket - (exp_pop ? chg : 0);
      if (nb < 0) nb = 0;
      nb = nb + int'(cfg_rate);
      if (nb > int'(cfg_burst)) nb = int'(cfg_burst);
      if (m_fin) begin
        if (!cfg_enable) begin m_run = 0; m_fin = 0; end
      end else if (m_hold) begin
        if (bus.tuple_out_ready) begin
          m_sent++;
          m_hold = 0;
          if (cfg_pkt_limit != 0 && m_sent == int'(cfg_pkt_limit)) m_fin = 1;
          else if (!cfg_enable) m_run = 0;
        end
      end else begin
        if (!cfg_enable) m_run = 0;
        else if (exp_pop) m_hold = 1;
      end
      m_bucket = nb;
    end

    @(posedge clk);
    #1;
    if (act_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  // Scoreboard monitor: every handshake must match the oldest outstanding entry.
  logic [EW-1:0]  mon_e;
  logic [ATW-1:0] prev_tuple;
  logic [PLW-1:0] prev_len;
  bit             prev_wait = 0;

  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.tuple_out_vld === 1'b1) begin
      if (prev_wait) begin
        check("stall_tuple_stable", bus.tuple_out, prev_tuple);
        check("stall_len_stable", ATW'(bus.pkt_len_out), ATW'(prev_len));
      end
      if (bus.tuple_out_ready === 1'b1) begin
        check("scoreboard_nonempty", ATW'(exp_q.size() != 0), ATW'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("tuple_out", bus.tuple_out, ATW'(mon_e[EW-1:16]));
          check("pkt_len_out", ATW'(bus.pkt_len_out), ATW'(mon_e[15:0]));
        end
      end
      prev_wait  = (bus.tuple_out_ready !== 1'b1);
      prev_tuple = bus.tuple_out;
      prev_len   = bus.pkt_len_out;
    end else begin
      prev_wait = 0;
    end
  end

  initial begin
    int c;
    bit seen;
    resetn = 1'b0; cfg_enable = 1'b0; cfg_rate = '0; cfg_burst = '0; cfg_pkt_limit = '0;
    bus.tuple_out_ready = 1'b1;
    drive_fifo();
    m_bucket = 0; m_sent = 0; m_run = 0; m_hold = 0; m_fin = 0;
    @(posedge clk); #1;
    repeat (3) cycle();
    check("reset_tuple_out", bus.tuple_out, '0);
    check("reset_pkt_len_out", ATW'(bus.pkt_len_out), '0);
    resetn = 1'b1;
    cycle();

    // Steady pacing: rate 8, burst 64, ten 64-byte entries.
    cfg_rate = 16'd8; cfg_burst = 24'd64;
    repeat (10) push_pkt(64);
    cfg_enable = 1'b1;
    cycle(); cycle();
    check("first_valid_two_cycles_after_enable", ATW'(bus.tuple_out_vld), ATW'(1));
    repeat (90) cycle();
    check("paced_sent_cnt", ATW'(sent_cnt), ATW'(10));
    cfg_enable = 1'b0;
    repeat (3) cycle();

    // Packet limit of 3 with 5 queued, then restart.
    cfg_pkt_limit = 32'd3;
    repeat (5) push_pkt(64);
    cfg_enable = 1'b1;
    repeat (40) cycle();
    check("limit_done", ATW'(done), ATW'(1));
    check("limit_sent_cnt", ATW'(sent_cnt), ATW'(3));
    check("limit_fifo_left", ATW'(fifo_q.size()), ATW'(2));
    cfg_enable = 1'b0;
    repeat (2) cycle();
    check("done_cleared_in_idle", ATW'(done), ATW'(0));
    cfg_pkt_limit = '0;
    cfg_enable = 1'b1;
    cycle();
    check("restart_sent_cnt_zero", ATW'(sent_cnt), ATW'(0));
    repeat (30) cycle();
    check("restart_drained", ATW'(fifo_q.size()), ATW'(0));
    cfg_enable = 1'b0;
    repeat (3) cycle();

    // Builder stall for more than 20 cycles.
    bus.tuple_out_ready = 1'b0;
    push_pkt(64);
    cfg_enable = 1'b1;
    repeat (25) cycle();
    check("stall_tokens_saturate", ATW'(dut.tokens), ATW'(64));
    check("stall_valid_held", ATW'(bus.tuple_out_vld), ATW'(1));
    bus.tuple_out_ready = 1'b1;
    repeat (3) cycle();
    cfg_enable = 1'b0;
    repeat (2) cycle();

    // Oversized packet: burst 100, rate 10, 1500 bytes.
    cfg_burst = 24'd100; cfg_rate = 16'd10;
    push_pkt(1500);
    cfg_enable = 1'b1;
    cycle(); cycle();
    check("oversize_clip_then_accrue", ATW'(dut.tokens), ATW'(10));
    repeat (20) cycle();
    check("oversize_sent", ATW'(sent_cnt), ATW'(1));
    cfg_enable = 1'b0;
    repeat (2) cycle();

    // Rate equal to per-packet charge: one tuple every two cycles.
    c = charge_of(64);
    cfg_rate = 16'(c); cfg_burst = TW'(c);
    repeat (6) push_pkt(64);
    cfg_enable = 1'b1;
    repeat (16) cycle();
    check("pair_sent_cnt", ATW'(sent_cnt), ATW'(6));
    check("pair_tokens_stable", ATW'(dut.tokens), ATW'(c));
    cfg_enable = 1'b0;
    repeat (2) cycle();

    // Enable dropped in WAIT with the FIFO non-empty.
    cfg_rate = 16'd1; cfg_burst = 24'd200;
    push_pkt(150); push_pkt(150);
    cfg_enable = 1'b1;
    repeat (5) cycle();
    cfg_enable = 1'b0;
    repeat (5) cycle();
    check("no_pop_when_disabled", ATW'(fifo_q.size()), ATW'(1));

    // Reset while a tuple is held in SEND.
    bus.tuple_out_ready = 1'b0;
    cfg_rate = 16'd200;
    cfg_enable = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.tuple_out_vld === 1'b1) begin seen = 1; break; end
      cycle();
    end
    check("reached_send_before_reset", ATW'(seen), ATW'(1));
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    check("rst_vld", ATW'(bus.tuple_out_vld), '0);
    check("rst_tuple", bus.tuple_out, '0);
    check("rst_len", ATW'(bus.pkt_len_out), '0);
    check("rst_sent_cnt", ATW'(sent_cnt), '0);
    check("rst_done", ATW'(done), '0);
    check("rst_tokens", ATW'(dut.tokens), '0);
    cfg_enable = 1'b0;
    bus.tuple_out_ready = 1'b1;
    repeat (2) cycle();

    // Randomized traffic, stalls, enable toggles and reconfiguration.
    cfg_rate = 16'd20; cfg_burst = 24'd300; cfg_pkt_limit = 32'd2;
    cfg_enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) push_pkt(int'($urandom_range(1, 400)));
      bus.tuple_out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) cfg_enable = !cfg_enable;
      if ($urandom_range(0, 99) == 0) begin
        cfg_rate      = 16'($urandom_range(1, 60));
        cfg_burst     = TW'($urandom_range(40, 500));
        cfg_pkt_limit = CW'($urandom_range(0, 4));
      end
      cycle();
    end

    // Drain everything left.
    cfg_enable = 1'b0;
    bus.tuple_out_ready = 1'b1;
    repeat (3) cycle();
    cfg_pkt_limit = '0; cfg_rate = 16'd1000; cfg_burst = 24'd5000;
    cfg_enable = 1'b1;
    for (int k = 0; k < 3000 && (fifo_q.size() != 0 || exp_q.size() != 0); k++) cycle();
    repeat (3) cycle();
    check("drain_fifo_empty", ATW'(fifo_q.size()), ATW'(0));
    check("drain_scoreboard_empty", ATW'(exp_q.size()), ATW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
